// File: rtl/slowframe_rx_detect_if.sv
// RX byte-stream bundle from the MAC into the slow-down frame detector.
interface slowframe_rx_detect_if;
  logic [7:0] RxData;
  logic       RxValid;
  logic       RxLast;
  logic       RxError;

  modport master (
    output RxData,
    output RxValid,
    output RxLast,
    output RxError
  );

  modport slave (
    input RxData,
    input RxValid,
    input RxLast,
    input RxError
  );
endinterface

// File: rtl/slowframe_rx_detect.sv
// Recognises host slow-down control frames in the RX byte stream, latches the
// requested FIFO fill amount and stretches a request level towards the
// slow-down generator, with a one-cycle gap between back-to-back requests.
module slowframe_rx_detect #(
  parameter logic [47:0] DEST_MAC   = 48'h6C_B3_11_52_A3_AF,
  parameter logic [15:0] ETHER_TYPE = 16'h005C,
  parameter logic [31:0] SLOW_MAGIC = 32'h534C4F57,
  parameter int unsigned STRETCH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  slowframe_rx_detect_if.slave rx,
  output logic                 HostRequestSlowDown,
  output logic [31:0]          HostFiFoFillAmt,
  output logic [15:0]          FramesAccepted,
  output logic [15:0]          FramesRejected
);

  localparam int unsigned CntW = $clog2(STRETCH);
  localparam logic [CntW-1:0] StretchLoad = CntW'(STRETCH - 1);

  typedef enum logic [1:0] {ParseHdr, ParsePayld, ParseDrop} parseState_t;
  typedef enum logic [1:0] {OutIdle, OutAssert, OutGap} outState_t;

  parseState_t parseQ, parseD;
  outState_t   outQ, outD;
  logic [10:0] idxQ, idxD;
  logic        destHitQ, destHitD;
  logic        bcastHitQ, bcastHitD;
  logic [31:0] shadowQ, shadowD;
  logic [CntW-1:0] cntQ, cntD;
  logic [7:0]  expByte;
  logic        byteBad;
  logic        accept;
  logic        reject;

  // Reference byte for the header/magic positions of the current index.
  always_comb begin
    expByte = 8'h00;
    case (idxQ)
      11'd0:   expByte = DEST_MAC[47:40];
      11'd1:   expByte = DEST_MAC[39:32];
      11'd2:   expByte = DEST_MAC[31:24];
      11'd3:   expByte = DEST_MAC[23:16];
      11'd4:   expByte = DEST_MAC[15:8];
      11'd5:   expByte = DEST_MAC[7:0];
      11'd12:  expByte = ETHER_TYPE[15:8];
      11'd13:  expByte = ETHER_TYPE[7:0];
      11'd14:  expByte = SLOW_MAGIC[31:24];
      11'd15:  expByte = SLOW_MAGIC[23:16];
      11'd16:  expByte = SLOW_MAGIC[15:8];
      11'd17:  expByte = SLOW_MAGIC[7:0];
      default: expByte = 8'h00;
    endcase
  end

  // Parse FSM next state, byte index, destination match tracking, fill shadow.
  always_comb begin
    parseD    = parseQ;
    idxD      = idxQ;
    destHitD  = destHitQ;
    bcastHitD = bcastHitQ;
    shadowD   = shadowQ;
    byteBad   = 1'b0;
    if (rx.RxValid) begin
      idxD = (idxQ == 11'h7FF) ? idxQ : idxQ + 11'd1;
      case (parseQ)
        ParseHdr: begin
          if (idxQ < 11'd6) begin
            // Unicast and broadcast are tracked separately so a mixed address fails.
            destHitD  = ((idxQ == 11'd0) | destHitQ) & (rx.RxData == expByte);
            bcastHitD = ((idxQ == 11'd0) | bcastHitQ) & (rx.RxData == 8'hFF);
            byteBad   = ~destHitD & ~bcastHitD;
          end else if (idxQ == 11'd12 || idxQ == 11'd13) begin
            byteBad = (rx.RxData != expByte);
            if (!byteBad && idxQ == 11'd13) parseD = ParsePayld;
          end
          if (byteBad) parseD = ParseDrop;
        end
        ParsePayld: begin
          if (idxQ >= 11'd14 && idxQ <= 11'd17) begin
            byteBad = (rx.RxData != expByte);
            if (byteBad) parseD = ParseDrop;
          end else if (idxQ >= 11'd18 && idxQ <= 11'd21) begin
            shadowD = {shadowQ[23:0], rx.RxData};
          end
        end
        ParseDrop: ;
        default: parseD = ParseHdr;
      endcase
      if (rx.RxLast) begin
        idxD   = 11'd0;
        parseD = ParseHdr;
      end
    end
  end

  assign accept = rx.RxValid & rx.RxLast & (parseQ != ParseDrop) & ~byteBad & ~rx.RxError &
                  (idxQ >= 11'd21);
  assign reject = rx.RxValid & rx.RxLast & ~accept;

  // Output FSM: stretch the request; a new accept while asserted forces a one-cycle gap.
  always_comb begin
    outD = outQ;
    cntD = cntQ;
    case (outQ)
      OutIdle: begin
        if (accept) begin
          outD = OutAssert;
          cntD = StretchLoad;
        end
      end
      OutAssert: begin
        if (accept) begin
          outD = OutGap;
        end else if (cntQ == '0) begin
          outD = OutIdle;
        end else begin
          cntD = cntQ - 1'b1;
        end
      end
      OutGap: begin
        outD = OutAssert;
        cntD = StretchLoad;
      end
      default: outD = OutIdle;
    endcase
  end

  assign HostRequestSlowDown = (outQ == OutAssert);

  // State registers for both FSMs and the parse datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parseQ    <= ParseHdr;
      outQ      <= OutIdle;
      idxQ      <= 11'd0;
      destHitQ  <= 1'b0;
      bcastHitQ <= 1'b0;
      shadowQ   <= 32'h0;
      cntQ      <= '0;
    end else begin
      parseQ    <= parseD;
      outQ      <= outD;
      idxQ      <= idxD;
      destHitQ  <= destHitD;
      bcastHitQ <= bcastHitD;
      shadowQ   <= shadowD;
      cntQ      <= cntD;
    end
  end

  // Fill amount and frame counters update on the edge closing the last byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HostFiFoFillAmt <= 32'h0;
      FramesAccepted  <= 16'h0;
      FramesRejected  <= 16'h0;
    end else begin
      if (accept) begin
        HostFiFoFillAmt <= shadowD;
        FramesAccepted  <= FramesAccepted + 16'd1;
      end
      if (reject) FramesRejected <= FramesRejected + 16'd1;
    end
  end

endmodule

// File: tb/tb_slowframe_rx_detect.sv
// Directed bench for the slow-down frame detector: a vector table of whole frames
// plus hand sequences for back-to-back frames and reset mid-frame.
module tb_slowframe_rx_detect;

  localparam logic [47:0] Dm = 48'h6CB31152A3AF;
  localparam logic [47:0] Bc = 48'hFFFFFFFFFFFF;
  localparam logic [15:0] Et = 16'h005C;
  localparam logic [31:0] Mg = 32'h534C4F57;

  logic clk = 1'b0;
  logic reset;
  logic req, reqL;
  logic [31:0] fill, fillL;
  logic [15:0] acc, rej, accL, rejL;

  int nApplied = 0;
  int nMiscompare = 0;

  slowframe_rx_detect_if rx ();

  slowframe_rx_detect dut (
    .clk                 (clk),
    .reset               (reset),
    .rx                  (rx),
    .HostRequestSlowDown (req),
    .HostFiFoFillAmt     (fill),
    .FramesAccepted      (acc),
    .FramesRejected      (rej)
  );

  // Longer stretch so a second frame can land while the request is still high.
  slowframe_rx_detect #(.STRETCH(32)) dutLong (
    .clk                 (clk),
    .reset               (reset),
    .rx                  (rx),
    .HostRequestSlowDown (reqL),
    .HostFiFoFillAmt     (fillL),
    .FramesAccepted      (accL),
    .FramesRejected      (rejL)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] dest;
    logic [15:0] etype;
    logic [31:0] magic;
    logic [31:0] fillIn;
    int          len;
    bit          err;
    int          stallAt;
    int          stallN;
    int          expHi;
    logic [31:0] expFill;
    logic [15:0] expAcc;
    logic [15:0] expRej;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nApplied++;
    if (got !== exp) begin
      nMiscompare++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input int i, input logic [47:0] d, input logic [15:0] e,
                                       input logic [31:0] m, input logic [31:0] f);
    if (i < 6) return d[8*(5-i) +: 8];
    if (i < 12) return 8'hA0 + 8'(i);
    if (i < 14) return e[8*(13-i) +: 8];
    if (i < 18) return m[8*(17-i) +: 8];
    if (i < 22) return f[8*(21-i) +: 8];
    return 8'(i);
  endfunction

  // Drives one byte per negedge; cut >= 0 stops before byte 'cut' without RxLast.
  task automatic sendFrame(input logic [47:0] d, input logic [15:0] e, input logic [31:0] m,
                           input logic [31:0] f, input int len, input bit err,
                           input int stallAt, input int stallN, input int cut);
    for (int i = 0; i < len; i++) begin
      if (cut >= 0 && i == cut) return;
      if (i == stallAt) begin
        for (int s = 0; s < stallN; s++) begin
          @(negedge clk);
          rx.RxValid = 1'b0;
          rx.RxLast  = 1'b1;  // RxLast without RxValid must be ignored
          rx.RxError = 1'b0;
          rx.RxData  = 8'hEE;
        end
      end
      @(negedge clk);
      rx.RxValid = 1'b1;
      rx.RxData  = fbyte(i, d, e, m, f);
      rx.RxLast  = (i == len - 1);
      rx.RxError = err && (i == len - 1);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    rx.RxValid = 1'b0;
    rx.RxLast  = 1'b0;
    rx.RxError = 1'b0;
    rx.RxData  = 8'h00;
  endtask

  task automatic measureReq(output logic first, output int hi);
    first = req;
    hi = 0;
    for (int k = 0; k < 24; k++) begin
      if (req) hi++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic first;
    int   hi;
    logic trM[80];
    logic trL[80];
    int   badM, badL;

    vecs[0] = '{Dm, Et, Mg, 32'h01020304, 64, 1'b0, -1, 0, 16, 32'h01020304, 16'd1, 16'd0};
    vecs[1] = '{Dm, Et, Mg, 32'h0BADF00D, 64, 1'b1, -1, 0, 0, 32'h01020304, 16'd1, 16'd1};
    vecs[2] = '{48'h112233445566, Et, Mg, 32'h0BADF00D, 64, 1'b0, -1, 0, 0, 32'h01020304,
                16'd1, 16'd2};
    vecs[3] = '{Dm, 16'h0800, Mg, 32'h0BADF00D, 64, 1'b0, -1, 0, 0, 32'h01020304, 16'd1, 16'd3};
    vecs[4] = '{Dm, Et, 32'h46415354, 32'h0BADF00D, 64, 1'b0, -1, 0, 0, 32'h01020304,
                16'd1, 16'd4};
    vecs[5] = '{Dm, Et, Mg, 32'h0BADF00D, 20, 1'b0, -1, 0, 0, 32'h01020304, 16'd1, 16'd5};
    vecs[6] = '{Dm, Et, Mg, 32'hAABBCCDD, 22, 1'b0, -1, 0, 16, 32'hAABBCCDD, 16'd2, 16'd5};
    vecs[7] = '{Dm, Et, Mg, 32'h99999999, 21, 1'b0, -1, 0, 0, 32'hAABBCCDD, 16'd2, 16'd6};
    vecs[8] = '{Bc, Et, Mg, 32'h55667788, 64, 1'b0, 19, 3, 16, 32'h55667788, 16'd3, 16'd6};
    vecs[9] = '{48'hFFFFFF52A3AF, Et, Mg, 32'h0BADF00D, 64, 1'b0, -1, 0, 0, 32'h55667788,
                16'd3, 16'd7};

    reset = 1'b1;
    rx.RxValid = 1'b0;
    rx.RxLast  = 1'b0;
    rx.RxError = 1'b0;
    rx.RxData  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset req", 32'(req), 32'd0);
    check("reset fill", fill, 32'h0);
    check("reset accepted", 32'(acc), 32'd0);
    check("reset rejected", 32'(rej), 32'd0);

    for (int v = 0; v < 10; v++) begin
      sendFrame(vecs[v].dest, vecs[v].etype, vecs[v].magic, vecs[v].fillIn, vecs[v].len,
                vecs[v].err, vecs[v].stallAt, vecs[v].stallN, -1);
      idle();
      measureReq(first, hi);
      check($sformatf("v%0d req at A+1", v), 32'(first), (vecs[v].expHi > 0) ? 32'd1 : 32'd0);
      check($sformatf("v%0d req high cycles", v), 32'(hi), 32'(vecs[v].expHi));
      check($sformatf("v%0d fill", v), fill, vecs[v].expFill);
      check($sformatf("v%0d accepted", v), 32'(acc), 32'(vecs[v].expAcc));
      check($sformatf("v%0d rejected", v), 32'(rej), 32'(vecs[v].expRej));
    end

    // Back-to-back 22-byte frames; the second lands while dutLong is still asserting.
    fork
      begin
        sendFrame(Dm, Et, Mg, 32'h11111111, 22, 1'b0, -1, 0, -1);
        sendFrame(Dm, Et, Mg, 32'h22222222, 22, 1'b0, -1, 0, -1);
        idle();
      end
      begin
        for (int k = 0; k < 80; k++) begin
          trM[k] = req;
          trL[k] = reqL;
          @(negedge clk);
        end
      end
    join
    badM = 0;
    badL = 0;
    for (int k = 0; k < 80; k++) begin
      if (trM[k] !== ((k >= 23 && k <= 38) || (k >= 45 && k <= 60))) badM++;
      if (trL[k] !== ((k >= 23 && k <= 44) || (k >= 46 && k <= 77))) badL++;
    end
    check("b2b stretch16 trace bad samples", 32'(badM), 32'd0);
    check("b2b stretch32 gap trace bad samples", 32'(badL), 32'd0);
    check("b2b fill", fill, 32'h22222222);
    check("b2b accepted", 32'(acc), 32'd5);
    check("b2b rejected", 32'(rej), 32'd7);

    // Reset in place of byte 16 of a valid frame, then a fresh frame.
    sendFrame(Dm, Et, Mg, 32'h0DEAD0FF, 64, 1'b0, -1, 0, 16);
    @(negedge clk);
    reset = 1'b1;
    rx.RxValid = 1'b0;
    rx.RxLast  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid-frame reset req", 32'(req), 32'd0);
    check("mid-frame reset fill", fill, 32'h0);
    check("mid-frame reset accepted", 32'(acc), 32'd0);
    check("mid-frame reset rejected", 32'(rej), 32'd0);
    sendFrame(Dm, Et, Mg, 32'h0A0B0C0D, 64, 1'b0, -1, 0, -1);
    idle();
    measureReq(first, hi);
    check("post-reset req at A+1", 32'(first), 32'd1);
    check("post-reset req high cycles", 32'(hi), 32'd16);
    check("post-reset fill", fill, 32'h0A0B0C0D);
    check("post-reset accepted", 32'(acc), 32'd1);
    check("post-reset rejected", 32'(rej), 32'd0);
    check("stretch32 accepted", 32'(accL), 32'd1);
    check("stretch32 rejected", 32'(rejL), 32'd0);
    check("stretch32 fill", fillL, 32'h0A0B0C0D);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
    $finish;
  end

endmodule
